// File: rtl/instr_loader_pkg.sv
// ---------------------------------------------------------------------------
// instr_loader_pkg
// Shared types for the INSTR_LOADER PC receive path.
//   pc_rx_state_e   : receiver FSM states (IDLE, REQ, WAIT, OUT, DRAIN)
//   DEFAULT_PC_W    : default PC / memory address width
//   DEFAULT_INSTR_W : default fetched instruction width
//   iss_entry_t     : one issued entry {pc, instr, exc} at default widths
// ---------------------------------------------------------------------------
package instr_loader_pkg;

    localparam int DEFAULT_PC_W    = 32;
    localparam int DEFAULT_INSTR_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        OUT,
        DRAIN
    } pc_rx_state_e;

    typedef struct packed {
        logic [DEFAULT_PC_W-1:0]    pc;
        logic [DEFAULT_INSTR_W-1:0] instr;
        logic                       exc;
    } iss_entry_t;

endpackage

// File: rtl/instr_pc_fifo.sv
// ---------------------------------------------------------------------------
// instr_pc_fifo
// Synchronous FIFO holding PCs waiting to be fetched.
// Pointers carry one extra wrap bit, so full/empty come straight from the
// pointer difference. clear_i has priority and drops a coincident push.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear_i    : empty the FIFO (push in the same cycle is dropped)
//   push_i     : write data_i (ignored when full)
//   pop_i      : advance read pointer (ignored when empty)
//   data_i     : write data
//   data_o     : head entry (valid when !empty_o)
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
//   count_o    : number of entries held
// ---------------------------------------------------------------------------
module instr_pc_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push;
    logic         do_pop;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == FULL_CNT);
    assign empty_o = (count_o == '0);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide
    // which entries are meaningful, and a reset-free array maps to RAM/LUTRAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/instr_loader_pc_rx.sv
// ---------------------------------------------------------------------------
// instr_loader_pc_rx
// Receiving end of the PC transfer from the instruction page walker.
// Buffers incoming PCs, fetches each one from instruction memory and issues
// {pc, instr} downstream in order. flush drops queued PCs and discards any
// memory response still outstanding.
// Optional feature macro: INSTR_LOADER_MISALIGN_CHK_EN
//   defined     : a popped PC with pc[1:0]!=0 is not fetched; it issues
//                 directly with iss_exc=1 and iss_instr=0.
//   not defined : every PC is fetched as-is, iss_exc is tied 0.
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   flush                           : drop all queued / in-flight work
//   pc_valid, pc_data, pc_ready     : PC input handshake (ready = FIFO not full)
//   mem_req_valid, mem_req_addr,
//   mem_req_ready                   : memory read request
//   mem_resp_valid, mem_resp_data   : memory read response (one per request)
//   iss_valid, iss_pc, iss_instr,
//   iss_exc, iss_ready              : issue output handshake
//   busy                            : FSM not idle or PCs queued
// ---------------------------------------------------------------------------
module instr_loader_pc_rx
    import instr_loader_pkg::*;
#(
    parameter int PC_W    = DEFAULT_PC_W,
    parameter int INSTR_W = DEFAULT_INSTR_W,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               pc_valid,
    input  logic [PC_W-1:0]    pc_data,
    output logic               pc_ready,
    output logic               mem_req_valid,
    output logic [PC_W-1:0]    mem_req_addr,
    input  logic               mem_req_ready,
    input  logic               mem_resp_valid,
    input  logic [INSTR_W-1:0] mem_resp_data,
    output logic               iss_valid,
    output logic [PC_W-1:0]    iss_pc,
    output logic [INSTR_W-1:0] iss_instr,
    output logic               iss_exc,
    input  logic               iss_ready,
    output logic               busy
);

    localparam int AW = $clog2(DEPTH);

    pc_rx_state_e       state_q, state_d;
    logic [PC_W-1:0]    cur_pc_q, cur_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               load;
    logic               pop;

    logic               fifo_full;
    logic               fifo_empty;
    logic [PC_W-1:0]    fifo_head;
    logic [AW:0]        fifo_count;

    // Ready depends on the registered count only, so a pop in the same
    // cycle never opens a slot for the walker.
    assign pc_ready = !fifo_full;

    instr_pc_fifo #(
        .W     (PC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .push_i  (pc_valid),
        .pop_i   (pop),
        .data_i  (pc_data),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

`ifdef INSTR_LOADER_MISALIGN_CHK_EN
    logic exc_q, exc_d;
    assign iss_exc = exc_q;
`else
    assign iss_exc = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cur_pc_d = cur_pc_q;
        instr_d  = instr_q;
`ifdef INSTR_LOADER_MISALIGN_CHK_EN
        exc_d    = exc_q;
`endif
        load     = 1'b0;

        case (state_q)
            IDLE:  if (!fifo_empty) load = 1'b1;
            REQ:   if (mem_req_ready) state_d = WAIT;
            WAIT:  if (mem_resp_valid) begin
                       instr_d = mem_resp_data;
                       state_d = OUT;
                   end
            OUT:   if (iss_ready) begin
                       if (!fifo_empty) load = 1'b1;
                       else             state_d = IDLE;
                   end
            DRAIN: if (mem_resp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        pop = load && !flush;

        // Take the FIFO head as the new current PC.
        if (pop) begin
            cur_pc_d = fifo_head;
            state_d  = REQ;
`ifdef INSTR_LOADER_MISALIGN_CHK_EN
            exc_d = (fifo_head[1:0] != 2'b00);
            if (fifo_head[1:0] != 2'b00) begin
                instr_d = '0;
                state_d = OUT;
            end
`endif
        end

        // Flush wins over everything. Once a request has been accepted its
        // response must still be swallowed, hence DRAIN; a response arriving
        // in the flush cycle itself already closes that request.
        if (flush) begin
            case (state_q)
                REQ:     state_d = mem_req_ready ? DRAIN : IDLE;
                WAIT:    state_d = mem_resp_valid ? IDLE : DRAIN;
                DRAIN:   state_d = mem_resp_valid ? IDLE : DRAIN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_pc_q <= '0;
            instr_q  <= '0;
`ifdef INSTR_LOADER_MISALIGN_CHK_EN
            exc_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cur_pc_q <= cur_pc_d;
            instr_q  <= instr_d;
`ifdef INSTR_LOADER_MISALIGN_CHK_EN
            exc_q    <= exc_d;
`endif
        end
    end

    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = cur_pc_q;
    assign iss_valid     = (state_q == OUT);
    assign iss_pc        = cur_pc_q;
    assign iss_instr     = instr_q;
    assign busy          = (state_q != IDLE) || (fifo_count != '0);

    // A response is only legal while one is outstanding.
    resp_only_when_pending: assert property (
        @(posedge clk) disable iff (rst)
        mem_resp_valid |-> (state_q == WAIT || state_q == DRAIN)
    );

endmodule

// File: tb/tb_instr_loader_pc_rx.sv
// ---------------------------------------------------------------------------
// tb_instr_loader_pc_rx
// Directed bench for instr_loader_pc_rx. Accepted PCs push their expected
// {pc, instr, exc} onto a scoreboard; every issue handshake pops and compares.
// Inputs change and outputs are observed at the falling clock edge.
// ---------------------------------------------------------------------------
module tb_instr_loader_pc_rx;
    import instr_loader_pkg::*;

    localparam int PC_W    = DEFAULT_PC_W;
    localparam int INSTR_W = DEFAULT_INSTR_W;
    localparam int DEPTH   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               pc_valid;
    logic [PC_W-1:0]    pc_data;
    logic               pc_ready;
    logic               mem_req_valid;
    logic [PC_W-1:0]    mem_req_addr;
    logic               mem_req_ready;
    logic               mem_resp_valid;
    logic [INSTR_W-1:0] mem_resp_data;
    logic               iss_valid;
    logic [PC_W-1:0]    iss_pc;
    logic [INSTR_W-1:0] iss_instr;
    logic               iss_exc;
    logic               iss_ready;
    logic               busy;

    always #5 clk = ~clk;

    instr_loader_pc_rx #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .pc_valid       (pc_valid),
        .pc_data        (pc_data),
        .pc_ready       (pc_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .iss_valid      (iss_valid),
        .iss_pc         (iss_pc),
        .iss_instr      (iss_instr),
        .iss_exc        (iss_exc),
        .iss_ready      (iss_ready),
        .busy           (busy)
    );

    iss_entry_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;
    bit  auto_mem = 1'b1;     // bench answers each accepted request one cycle later
    bit  expect_drop = 1'b0;  // accepted PCs are expected to be flushed, not issued
    bit  last_push;

    // Memory contents seen by the bench.
    function automatic logic [INSTR_W-1:0] model_instr(input logic [PC_W-1:0] pc);
        if (pc == 32'h0000_1000) return 32'h0000_0013;
        return pc ^ 32'h5A00_0013;
    endfunction

    function automatic iss_entry_t expect_for(input logic [PC_W-1:0] pc);
        iss_entry_t e;
        e.pc    = pc;
        e.instr = model_instr(pc);
        e.exc   = 1'b0;
`ifdef INSTR_LOADER_MISALIGN_CHK_EN
        if (pc[1:0] != 2'b00) begin
            e.instr = '0;
            e.exc   = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: score this cycle's handshakes, then advance to the next falling edge.
    task automatic cyc();
        logic            fire_req;
        logic [PC_W-1:0] req_addr;
        iss_entry_t      e;
        if (iss_valid && iss_ready) begin
            check("iss_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("iss_pc",    64'(iss_pc),    64'(e.pc));
                check("iss_instr", 64'(iss_instr), 64'(e.instr));
                check("iss_exc",   64'(iss_exc),   64'(e.exc));
            end
        end
        last_push = pc_valid && pc_ready && !flush && !rst;
        if (last_push && !expect_drop) sb.push_back(expect_for(pc_data));
        fire_req = mem_req_valid && mem_req_ready && !rst;
        req_addr = mem_req_addr;
        @(posedge clk);
        @(negedge clk);
        if (auto_mem) begin
            mem_resp_valid = fire_req;
            mem_resp_data  = fire_req ? model_instr(req_addr) : '0;
        end
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
            cyc();
        end
        check({tag, "_drain_done"}, 64'(done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, required end before 200000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int              acc;
        logic [PC_W-1:0] nxt;

        rst            = 1'b1;
        flush          = 1'b0;
        pc_valid       = 1'b0;
        pc_data        = '0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        iss_ready      = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_pc_ready",      64'(pc_ready),      64'd1);
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_iss_valid",     64'(iss_valid),     64'd0);
        check("rst_iss_exc",       64'(iss_exc),       64'd0);
        check("rst_busy",          64'(busy),          64'd0);

        // T2: single fetch with a zero-wait memory
        pc_valid = 1'b1; pc_data = 32'h0000_1000;
        cyc();                                            // T: push
        pc_valid = 1'b0;
        check("t2_no_req_t1", 64'(mem_req_valid), 64'd0);
        cyc();                                            // T+1: pop
        check("t2_req_valid", 64'(mem_req_valid), 64'd1);
        check("t2_req_addr",  64'(mem_req_addr),  64'h1000);
        cyc();                                            // T+2: request accepted
        check("t2_no_iss_t3", 64'(iss_valid), 64'd0);
        cyc();                                            // T+3: response
        check("t2_iss_valid", 64'(iss_valid), 64'd1);
        check("t2_iss_pc",    64'(iss_pc),    64'h1000);
        check("t2_iss_instr", 64'(iss_instr), 64'h13);
        cyc();                                            // T+4: issued
        check("t2_idle_busy", 64'(busy), 64'd0);

        // T1: asynchronous reset while waiting for a response
        auto_mem = 1'b0; expect_drop = 1'b1;
        pc_valid = 1'b1; pc_data = 32'h0000_1100;
        cyc();
        pc_valid = 1'b0;
        cyc();
        cyc();
        check("t1_wait_busy", 64'(busy),          64'd1);
        check("t1_wait_noreq", 64'(mem_req_valid), 64'd0);
        #2 rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t1_pc_ready",      64'(pc_ready),      64'd1);
        check("t1_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("t1_iss_valid",     64'(iss_valid),     64'd0);
        check("t1_busy",          64'(busy),          64'd0);
        auto_mem = 1'b1; expect_drop = 1'b0;

        // T3: fill under issue backpressure, then release
        iss_ready = 1'b0;
        acc = 0; nxt = '0;
        pc_valid = 1'b1; pc_data = nxt;
        for (int i = 0; i < 20 && acc < 5; i++) begin
            cyc();
            if (last_push) begin
                acc++;
                nxt = nxt + 32'd4;
                pc_data = nxt;
            end
        end
        check("t3_accepts",     64'(acc),       64'd5);
        check("t3_full_ready",  64'(pc_ready),  64'd0);
        check("t3_out_valid",   64'(iss_valid), 64'd1);
        check("t3_out_pc",      64'(iss_pc),    64'h0);
        repeat (3) begin
            cyc();
            check("t3_held_ready", 64'(pc_ready), 64'd0);
        end
        iss_ready = 1'b1;
        check("t3_no_passthru", 64'(pc_ready), 64'd0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (last_push) break;
        end
        check("t3_sixth_accepted", 64'(last_push), 64'd1);
        pc_valid = 1'b0;
        drain("t3");

        // T4: flush while a response is pending
        auto_mem = 1'b0; expect_drop = 1'b1;
        pc_valid = 1'b1; pc_data = 32'h0000_2100;
        cyc();
        pc_valid = 1'b0;
        cyc();
        cyc();
        check("t4_wait_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("t4_fifo_empty_ready", 64'(pc_ready), 64'd1);
        check("t4_drain_busy",       64'(busy),     64'd1);
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_DEAD;
        cyc();
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        check("t4_no_issue", 64'(iss_valid), 64'd0);
        check("t4_idle",     64'(busy),      64'd0);
        auto_mem = 1'b1; expect_drop = 1'b0;
        pc_valid = 1'b1; pc_data = 32'h0000_2000;
        cyc();
        pc_valid = 1'b0;
        drain("t4");

        // T5: push coincident with flush is dropped
        pc_valid = 1'b1; pc_data = 32'h0000_3000; flush = 1'b1;
        cyc();
        pc_valid = 1'b0; flush = 1'b0;
        check("t5_busy", 64'(busy), 64'd0);
        repeat (3) begin
            cyc();
            check("t5_no_req", 64'(mem_req_valid), 64'd0);
        end

        // T6: misaligned PC
        pc_valid = 1'b1; pc_data = 32'h0000_1002;
        cyc();
        pc_valid = 1'b0;
        cyc();
`ifdef INSTR_LOADER_MISALIGN_CHK_EN
        check("t6_no_req",    64'(mem_req_valid), 64'd0);
        check("t6_iss_valid", 64'(iss_valid),     64'd1);
        check("t6_iss_exc",   64'(iss_exc),       64'd1);
        check("t6_iss_instr", 64'(iss_instr),     64'd0);
        check("t6_iss_pc",    64'(iss_pc),        64'h1002);
`else
        check("t6_req_valid", 64'(mem_req_valid), 64'd1);
        check("t6_req_addr",  64'(mem_req_addr),  64'h1002);
`endif
        drain("t6");

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
